// File: rtl/ibex_multdiv_arb_pkg.sv
// ibex_multdiv_arb_pkg
// Shared types and constants for the multiply/divide sequencer-arbiter.
//   md_op_e      : operator encoding as seen by ibex_multdiv_slow
//   arb_state_e  : sequencer states
//   DIV0_QUOTIENT: quotient returned for a divide by zero
//   MAX_REQ      : largest supported number of requesters
package ibex_multdiv_arb_pkg;

  typedef enum logic [1:0] {
    MD_OP_MULL = 2'd0,
    MD_OP_MULH = 2'd1,
    MD_OP_DIV  = 2'd2,
    MD_OP_REM  = 2'd3
  } md_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } arb_state_e;

  localparam logic [31:0] DIV0_QUOTIENT = 32'hFFFF_FFFF;
  localparam int          MAX_REQ       = 8;

  // DIV and REM run on the divider; MULL and MULH on the multiplier.
  function automatic logic is_div_op(md_op_e op);
    return (op == MD_OP_DIV) || (op == MD_OP_REM);
  endfunction

endpackage

// File: rtl/ibex_rr_arbiter.sv
// ibex_rr_arbiter
// Combinational round-robin picker: grants the first set request strictly
// after the last winner, wrapping around.
//   req_i  : per-requester request vector
//   last_i : index of the previous winner
//   gnt_o  : one-hot grant (zero when no request is set)
//   idx_o  : index of the granted requester (0 when no request is set)
module ibex_rr_arbiter #(
  parameter int NUM_REQ = 2,
  localparam int IDX_W  = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   last_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [IDX_W-1:0]   idx_o
);

  // First pass finds the lowest set request (the wrap-around winner); the
  // second pass overrides it with the lowest request above last_i if any.
  always_comb begin
    idx_o = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req_i[i]) idx_o = IDX_W'(i);
    end
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req_i[i] && (IDX_W'(i) > last_i)) idx_o = IDX_W'(i);
    end
    gnt_o = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      gnt_o[i] = (|req_i) && (idx_o == IDX_W'(i));
    end
  end

endmodule

// File: rtl/ibex_multdiv_arb.sv
// ibex_multdiv_arb
// Shares one ibex_multdiv_slow between NUM_REQ requesters. One request is
// latched at a time, the unit enable is held until completion (or kill) and
// the result is returned to the owner as a one-cycle pulse.
// Ports:
//   clk_i, rst_i             : clock, asynchronous active-high reset
//   req_i/operator_i/signed_mode_i/op_a_i/op_b_i : per-requester request
//   kill_i                   : abort the in-flight operation
//   gnt_o                    : one-hot grant pulse (combinational, IDLE only)
//   rsp_valid_o/rsp_result_o : one-hot response pulse and data
//   busy_o                   : high while not IDLE
//   md_*_o, md_valid_i, md_result_i : interface to the shared unit
// Optional feature: define MULTDIV_ARB_DIV0_BYPASS_EN to answer DIV/REM by
// zero directly without enabling the unit.
module ibex_multdiv_arb
  import ibex_multdiv_arb_pkg::*;
#(
  parameter int NUM_REQ = 2
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [NUM_REQ-1:0]   req_i,
  input  logic [2*NUM_REQ-1:0] operator_i,
  input  logic [2*NUM_REQ-1:0] signed_mode_i,
  input  logic [32*NUM_REQ-1:0] op_a_i,
  input  logic [32*NUM_REQ-1:0] op_b_i,
  input  logic                 kill_i,
  output logic [NUM_REQ-1:0]   gnt_o,
  output logic [NUM_REQ-1:0]   rsp_valid_o,
  output logic [31:0]          rsp_result_o,
  output logic                 busy_o,
  output logic                 md_mult_en_o,
  output logic                 md_div_en_o,
  output logic [1:0]           md_operator_o,
  output logic [1:0]           md_signed_mode_o,
  output logic [31:0]          md_op_a_o,
  output logic [31:0]          md_op_b_o,
  input  logic                 md_valid_i,
  input  logic [31:0]          md_result_i
);

  localparam int IDX_W = $clog2(NUM_REQ);

  arb_state_e       state_q, state_d;
  logic [IDX_W-1:0] last_q, last_d;
  logic [IDX_W-1:0] owner_q, owner_d;
  md_op_e           op_q, op_d;
  logic [1:0]       signed_q, signed_d;
  logic [31:0]      a_q, a_d;
  logic [31:0]      b_q, b_d;
  logic [31:0]      result_q, result_d;

  logic [NUM_REQ-1:0] arb_gnt;
  logic [IDX_W-1:0]   arb_idx;
  md_op_e             req_op;
  logic [1:0]         req_signed;
  logic [31:0]        req_a;
  logic [31:0]        req_b;

  ibex_rr_arbiter #(
    .NUM_REQ(NUM_REQ)
  ) u_rr_arbiter (
    .req_i (req_i),
    .last_i(last_q),
    .gnt_o (arb_gnt),
    .idx_o (arb_idx)
  );

  // Select the winning requester's operation fields.
  always_comb begin
    req_op     = MD_OP_MULL;
    req_signed = '0;
    req_a      = '0;
    req_b      = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (arb_idx == IDX_W'(i)) begin
        req_op     = md_op_e'(operator_i[2*i +: 2]);
        req_signed = signed_mode_i[2*i +: 2];
        req_a      = op_a_i[32*i +: 32];
        req_b      = op_b_i[32*i +: 32];
      end
    end
  end

  // Sequencer next-state logic. Kill wins over a same-cycle completion.
  always_comb begin
    state_d  = state_q;
    last_d   = last_q;
    owner_d  = owner_q;
    op_d     = op_q;
    signed_d = signed_q;
    a_d      = a_q;
    b_d      = b_q;
    result_d = result_q;
    unique case (state_q)
      IDLE: begin
        if (|req_i) begin
          last_d   = arb_idx;
          owner_d  = arb_idx;
          op_d     = req_op;
          signed_d = req_signed;
          a_d      = req_a;
          b_d      = req_b;
          state_d  = BUSY;
`ifdef MULTDIV_ARB_DIV0_BYPASS_EN
          if (is_div_op(req_op) && (req_b == '0)) begin
            result_d = (req_op == MD_OP_DIV) ? DIV0_QUOTIENT : req_a;
            state_d  = RESP;
          end
`endif
        end
      end
      BUSY: begin
        if (kill_i) begin
          state_d = IDLE;
        end else if (md_valid_i) begin
          result_d = md_result_i;
          state_d  = RESP;
        end
      end
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      last_q   <= IDX_W'(NUM_REQ - 1);
      owner_q  <= '0;
      op_q     <= MD_OP_MULL;
      signed_q <= '0;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      last_q   <= last_d;
      owner_q  <= owner_d;
      op_q     <= op_d;
      signed_q <= signed_d;
      a_q      <= a_d;
      b_q      <= b_d;
      result_q <= result_d;
    end
  end

  // Grant is masked by reset so every output reads zero while reset is held.
  assign gnt_o            = ((state_q == IDLE) && !rst_i) ? arb_gnt : '0;
  assign busy_o           = (state_q != IDLE);
  assign md_mult_en_o     = (state_q == BUSY) && !is_div_op(op_q);
  assign md_div_en_o      = (state_q == BUSY) && is_div_op(op_q);
  assign md_operator_o    = op_q;
  assign md_signed_mode_o = signed_q;
  assign md_op_a_o        = a_q;
  assign md_op_b_o        = b_q;
  assign rsp_result_o     = (state_q == RESP) ? result_q : '0;

  always_comb begin
    rsp_valid_o = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      rsp_valid_o[i] = (state_q == RESP) && (owner_q == IDX_W'(i));
    end
  end

endmodule

// File: tb/tb_ibex_multdiv_arb.sv
// tb_ibex_multdiv_arb
// Randomized bench for ibex_multdiv_arb with three requesters. Requesters
// raise requests at random and hold them until granted; the bench plays the
// shared unit, answering after a random latency and sometimes killing.
// Expected grants, enable windows and response cycles come from a timeline
// model; expected responses go into a scoreboard that a separate monitor
// drains. Honours MULTDIV_ARB_DIV0_BYPASS_EN in the model.
module tb_ibex_multdiv_arb;

  localparam int N = 3;

  logic            clk_i = 1'b0;
  logic            rst_i;
  logic [N-1:0]    req_i;
  logic [2*N-1:0]  operator_i;
  logic [2*N-1:0]  signed_mode_i;
  logic [32*N-1:0] op_a_i;
  logic [32*N-1:0] op_b_i;
  logic            kill_i;
  logic [N-1:0]    gnt_o;
  logic [N-1:0]    rsp_valid_o;
  logic [31:0]     rsp_result_o;
  logic            busy_o;
  logic            md_mult_en_o;
  logic            md_div_en_o;
  logic [1:0]      md_operator_o;
  logic [1:0]      md_signed_mode_o;
  logic [31:0]     md_op_a_o;
  logic [31:0]     md_op_b_o;
  logic            md_valid_i;
  logic [31:0]     md_result_i;

  ibex_multdiv_arb #(.NUM_REQ(N)) dut (
    .clk_i           (clk_i),
    .rst_i           (rst_i),
    .req_i           (req_i),
    .operator_i      (operator_i),
    .signed_mode_i   (signed_mode_i),
    .op_a_i          (op_a_i),
    .op_b_i          (op_b_i),
    .kill_i          (kill_i),
    .gnt_o           (gnt_o),
    .rsp_valid_o     (rsp_valid_o),
    .rsp_result_o    (rsp_result_o),
    .busy_o          (busy_o),
    .md_mult_en_o    (md_mult_en_o),
    .md_div_en_o     (md_div_en_o),
    .md_operator_o   (md_operator_o),
    .md_signed_mode_o(md_signed_mode_o),
    .md_op_a_o       (md_op_a_o),
    .md_op_b_o       (md_op_b_o),
    .md_valid_i      (md_valid_i),
    .md_result_i     (md_result_i)
  );

  always #5 clk_i = ~clk_i;

  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  typedef struct {
    int          owner;
    logic [31:0] result;
    int          cyc;
  } rsp_t;

  rsp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  // Pending request per requester
  bit          pend[N];
  logic [1:0]  p_op[N];
  logic [1:0]  p_sm[N];
  logic [31:0] p_a[N];
  logic [31:0] p_b[N];

  // Timeline of the current operation
  int          last_m;
  int          idle_at;
  int          cur_g;
  int          en_end;
  int          valid_cyc;
  int          kill_cyc;
  int          force_lat;
  bit          cur_pushed;
  logic [1:0]  cur_op;
  logic [1:0]  cur_sm;
  logic [31:0] cur_a;
  logic [31:0] cur_b;
  logic [31:0] cur_res;
  logic [N-1:0] exp_gnt;

  // What the shared unit computes (unsigned arithmetic, RISC-V div-by-zero)
  function automatic logic [31:0] unit_result(logic [1:0] op, logic [31:0] a, logic [31:0] b);
    logic [63:0] p;
    p = {32'd0, a} * {32'd0, b};
    case (op)
      2'd0:    return p[31:0];
      2'd1:    return p[63:32];
      2'd2:    return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
      default: return (b == 32'd0) ? a : a % b;
    endcase
  endfunction

  function automatic bit any_pending();
    for (int r = 0; r < N; r++) if (pend[r]) return 1'b1;
    return 1'b0;
  endfunction

  // Pending requester with the smallest rotational distance after last_m
  function automatic int rr_pick();
    int best  = -1;
    int bestd = N + 1;
    for (int r = 0; r < N; r++) begin
      if (pend[r]) begin
        int d;
        d = (r - last_m - 1 + 2 * N) % N;
        if (d < bestd) begin
          bestd = d;
          best  = r;
        end
      end
    end
    return best;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  // Drive one cycle of requester and unit behaviour; advance the model.
  task automatic applyStimulus(input bit allow_new);
    int   k;
    int   lat;
    int   kk;
    bit   bypass;
    bit   in_busy;
    rsp_t e;
    if (allow_new) begin
      for (int r = 0; r < N; r++) begin
        if (!pend[r] && $urandom_range(0, 3) == 0) begin
          pend[r] = 1'b1;
          p_op[r] = 2'($urandom_range(0, 3));
          p_sm[r] = 2'($urandom_range(0, 3));
          p_a[r]  = $urandom;
          p_b[r]  = ($urandom_range(0, 3) == 0) ? 32'd0 : 32'($urandom);
        end
      end
    end
    for (int r = 0; r < N; r++) begin
      req_i[r]                 = pend[r];
      operator_i[2*r +: 2]     = pend[r] ? p_op[r] : 2'($urandom_range(0, 3));
      signed_mode_i[2*r +: 2]  = pend[r] ? p_sm[r] : 2'($urandom_range(0, 3));
      op_a_i[32*r +: 32]       = pend[r] ? p_a[r] : 32'($urandom);
      op_b_i[32*r +: 32]       = pend[r] ? p_b[r] : 32'($urandom);
    end
    exp_gnt = '0;
    if (cyc >= idle_at && any_pending()) begin
      k            = rr_pick();
      exp_gnt[k]   = 1'b1;
      pend[k]      = 1'b0;
      last_m       = k;
      cur_g        = cyc;
      cur_op       = p_op[k];
      cur_sm       = p_sm[k];
      cur_a        = p_a[k];
      cur_b        = p_b[k];
      cur_res      = unit_result(cur_op, cur_a, cur_b);
      cur_pushed   = 1'b0;
      valid_cyc    = -1;
      kill_cyc     = -1;
      e.owner      = k;
      e.result     = cur_res;
      bypass       = 1'b0;
`ifdef MULTDIV_ARB_DIV0_BYPASS_EN
      bypass = (cur_op >= 2'd2) && (cur_b == 32'd0);
`endif
      if (bypass) begin
        en_end  = cyc;
        idle_at = cyc + 2;
        e.cyc   = cyc + 1;
        sb.push_back(e);
        cur_pushed = 1'b1;
      end else begin
        lat       = (force_lat > 0) ? force_lat : int'($urandom_range(1, 4));
        valid_cyc = cyc + lat;
        en_end    = cyc + lat;
        if (force_lat == 0 && $urandom_range(0, 4) == 0) begin
          kk       = int'($urandom_range(1, lat));
          kill_cyc = cyc + kk;
          en_end   = kill_cyc;
          idle_at  = kill_cyc + 1;
          if (kk != lat) valid_cyc = -1;
        end else begin
          idle_at = cyc + lat + 2;
          e.cyc   = cyc + lat + 1;
          sb.push_back(e);
          cur_pushed = 1'b1;
        end
      end
    end
    in_busy     = (cyc > cur_g) && (cyc <= en_end);
    md_valid_i  = (cyc == valid_cyc) || (!in_busy && $urandom_range(0, 2) == 0);
    kill_i      = (cyc == kill_cyc) || (!in_busy && $urandom_range(0, 2) == 0);
    md_result_i = (cyc == valid_cyc) ? cur_res : 32'($urandom);
  endtask

  task automatic checkCycle();
    bit in_busy;
    in_busy = (cyc > cur_g) && (cyc <= en_end);
    checkOutput("gnt", gnt_o, exp_gnt);
    checkOutput("busy", busy_o, (cyc > cur_g) && (cyc < idle_at));
    checkOutput("mult_en", md_mult_en_o, in_busy && (cur_op < 2'd2));
    checkOutput("div_en", md_div_en_o, in_busy && (cur_op >= 2'd2));
    if (in_busy) begin
      checkOutput("md_operator", md_operator_o, cur_op);
      checkOutput("md_signed", md_signed_mode_o, cur_sm);
      checkOutput("md_op_a", md_op_a_o, cur_a);
      checkOutput("md_op_b", md_op_b_o, cur_b);
    end
  endtask

  task automatic runCycle(input bit allow_new);
    applyStimulus(allow_new);
    @(negedge clk_i);
    checkCycle();
    @(posedge clk_i);
    #1;
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_gnt"}, gnt_o, 0);
    checkOutput({tag, "_busy"}, busy_o, 0);
    checkOutput({tag, "_mult_en"}, md_mult_en_o, 0);
    checkOutput({tag, "_div_en"}, md_div_en_o, 0);
    checkOutput({tag, "_rsp_valid"}, rsp_valid_o, 0);
    checkOutput({tag, "_rsp_result"}, rsp_result_o, 0);
    checkOutput({tag, "_md_op_a"}, md_op_a_o, 0);
    checkOutput({tag, "_md_op_b"}, md_op_b_o, 0);
  endtask

  task automatic setPending(input int r, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    pend[r] = 1'b1;
    p_op[r] = op;
    p_sm[r] = 2'd0;
    p_a[r]  = a;
    p_b[r]  = b;
  endtask

  initial begin
    rst_i = 1'b1; req_i = '0; operator_i = '0; signed_mode_i = '0;
    op_a_i = '0; op_b_i = '0; kill_i = 1'b0; md_valid_i = 1'b0; md_result_i = '0;
    for (int r = 0; r < N; r++) pend[r] = 1'b0;
    last_m = N - 1; idle_at = 0; cur_g = -10; en_end = -10;
    valid_cyc = -1; kill_cyc = -1; force_lat = 0; cur_pushed = 1'b0;
    cur_op = '0; cur_sm = '0; cur_a = '0; cur_b = '0; cur_res = '0; exp_gnt = '0;

    repeat (2) @(posedge clk_i);
    req_i = '1;
    @(negedge clk_i);
    checkAllZero("reset");

    // Response monitor: pops the scoreboard whenever a response appears.
    fork
      begin
        rsp_t m;
        forever begin
          @(negedge clk_i);
          if (rsp_valid_o != '0) begin
            if (sb.size() == 0) begin
              checkOutput("rsp_unexpected", rsp_valid_o, 0);
            end else begin
              m = sb.pop_front();
              checkOutput("rsp_owner", rsp_valid_o, 64'd1 << m.owner);
              checkOutput("rsp_result", rsp_result_o, m.result);
              checkOutput("rsp_cycle", cyc, m.cyc);
            end
          end else if (sb.size() != 0 && sb[0].cyc <= cyc) begin
            m = sb.pop_front();
            checkOutput("rsp_missing", rsp_valid_o, 64'd1 << m.owner);
          end
        end
      end
    join_none

    @(posedge clk_i);
    #1;
    rst_i   = 1'b0;
    idle_at = cyc;
    $display("[TB] reset released, two DIV 100/7 requests first");

    // Both requesters ask at once from reset: 0 then 1, each answers 14.
    setPending(0, 2'd2, 32'd100, 32'd7);
    setPending(1, 2'd2, 32'd100, 32'd7);
    force_lat = 2;
    repeat (12) runCycle(1'b0);
    force_lat = 0;

    repeat (400) runCycle(1'b1);
    for (int i = 0; i < 100 && (any_pending() || cyc < idle_at || sb.size() != 0); i++) runCycle(1'b0);

    // Reset during BUSY: everything drops at once, requester 0 wins next.
    $display("[TB] reset during busy");
    for (int r = 0; r < N; r++) setPending(r, 2'd0, 32'd7, 32'd6);
    force_lat = 4;
    runCycle(1'b0);
    runCycle(1'b0);
    applyStimulus(1'b0);
    @(negedge clk_i);
    checkCycle();
    checkOutput("pre_reset_mult_en", md_mult_en_o, 1);
    #2;
    rst_i = 1'b1;
    md_valid_i = 1'b0;
    kill_i = 1'b0;
    #1;
    checkAllZero("midreset");
    if (cur_pushed) void'(sb.pop_back());
    cur_pushed = 1'b0; cur_g = -10; en_end = -10; valid_cyc = -1; kill_cyc = -1;
    last_m = N - 1;
    for (int r = 0; r < N; r++) setPending(r, 2'd0, 32'd7, 32'd6);
    @(posedge clk_i);
    #1;
    rst_i   = 1'b0;
    idle_at = cyc;
    force_lat = 3;
    runCycle(1'b0);
    checkOutput("post_reset_winner", last_m, 0);
    for (int i = 0; i < 60 && (any_pending() || cyc < idle_at || sb.size() != 0); i++) runCycle(1'b0);
    @(negedge clk_i);
    checkOutput("drain_scoreboard", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
